// File: rtl/csr_dense_streamer.sv
// -----------------------------------------------------------------------------
// csr_dense_streamer
//
// Captures a CSR matrix (non-zero values NV, column indices CI, row pointers RP)
// when start is accepted, then streams it out as a dense row-major matrix, one
// element per valid/ready beat. Positions with no stored entry come out as 0.
// Each row costs one setup bubble followed by one beat per column.
//
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_i            synchronous active-high reset
//   start_i          capture arrays and begin (honoured only while idle)
//   rows_i           row count, 0..MAX_NNZ-1 (0 finishes with no beats)
//   cols_i           column count, 1..MAX_NNZ (0 means MAX_NNZ)
//   NV_i/CI_i/RP_i   CSR arrays: values, column indices, row pointers
//   data_o           dense element value
//   row_o/col_o      coordinates of data_o
//   valid_o/ready_i  element beat handshake
//   last_row_elem_o  beat is the final column of its row
//   last_o           beat is the final element of the matrix
//   busy_o           high from start acceptance until the done cycle
//   done_o           one-cycle pulse after the final beat is accepted
//   err_o            sticky malformed-CSR flag, cleared by the next start
// -----------------------------------------------------------------------------
module csr_dense_streamer #(
  parameter int DATA_W  = 32,
  parameter int MAX_NNZ = 16,
  parameter int IDX_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [IDX_W-1:0]  rows_i,
  input  logic [IDX_W:0]    cols_i,
  input  logic [DATA_W-1:0] NV_i [MAX_NNZ],
  input  logic [IDX_W-1:0]  CI_i [MAX_NNZ],
  input  logic [IDX_W-1:0]  RP_i [MAX_NNZ],
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  row_o,
  output logic [IDX_W-1:0]  col_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_row_elem_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ROW_SETUP = 2'd1;
  localparam logic [1:0] S_EMIT      = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  localparam logic [IDX_W:0] COLS_MAX = (IDX_W+1)'(MAX_NNZ);

  logic [1:0]        state;
  logic [DATA_W-1:0] nv_q [MAX_NNZ];
  logic [IDX_W-1:0]  ci_q [MAX_NNZ];
  logic [IDX_W-1:0]  rp_q [MAX_NNZ];
  logic [IDX_W-1:0]  rows_q;
  logic [IDX_W:0]    cols_q;
  logic [IDX_W-1:0]  r;      // current row
  logic [IDX_W-1:0]  k;      // next unconsumed entry of the current row
  logic [IDX_W-1:0]  kend;   // one past the last entry of the current row
  logic [IDX_W:0]    c;      // current column, one extra bit so cols=MAX_NNZ fits

  logic              emit;
  logic              hit;
  logic              last_col;
  logic              last_row;
  logic [IDX_W-1:0]  r_next;
  logic [IDX_W-1:0]  k_after;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    emit     = (state == S_EMIT);
    hit      = 1'b0;
    r_next   = r + IDX_W'(1);
    last_col = (c == cols_q - (IDX_W+1)'(1));
    last_row = (r == rows_q - IDX_W'(1));
    if (k < kend) begin
      hit = ({1'b0, ci_q[k]} == c);
    end
    k_after = hit ? k + IDX_W'(1) : k;

    // Beat outputs derive purely from held state, so they stay stable for as
    // long as the sink stalls.
    valid_o         = emit;
    data_o          = '0;
    row_o           = '0;
    col_o           = '0;
    last_row_elem_o = 1'b0;
    last_o          = 1'b0;
    if (emit) begin
      data_o          = hit ? nv_q[k] : '0;
      row_o           = r;
      col_o           = c[IDX_W-1:0];
      last_row_elem_o = last_col;
      last_o          = last_col && last_row;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      // NOTE: the captured arrays are reset too, so a stream after reset
      // never exposes stale matrix contents.
      nv_q   <= '{default: '0};
      ci_q   <= '{default: '0};
      rp_q   <= '{default: '0};
      rows_q <= '0;
      cols_q <= '0;
      r      <= '0;
      k      <= '0;
      kend   <= '0;
      c      <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            nv_q   <= NV_i;
            ci_q   <= CI_i;
            rp_q   <= RP_i;
            rows_q <= rows_i;
            cols_q <= (cols_i == '0) ? COLS_MAX : cols_i;
            r      <= '0;
            err_o  <= 1'b0;
            busy_o <= 1'b1;
            state  <= (rows_i == '0) ? S_DONE : S_ROW_SETUP;
          end
        end

        S_ROW_SETUP: begin
          k <= rp_q[r];
          c <= '0;
          // A decreasing row pointer is malformed; the row streams as empty.
          if (rp_q[r_next] < rp_q[r]) begin
            err_o <= 1'b1;
            kend  <= rp_q[r];
          end else begin
            kend  <= rp_q[r_next];
          end
          state <= S_EMIT;
        end

        S_EMIT: begin
          if (ready_i) begin
            k <= k_after;
            c <= c + (IDX_W+1)'(1);
            if (last_col) begin
              // Entries left unconsumed mean CI was unordered, duplicated or
              // outside the column range.
              if (k_after != kend) begin
                err_o <= 1'b1;
              end
              if (last_row) begin
                state <= S_DONE;
              end else begin
                r     <= r_next;
                state <= S_ROW_SETUP;
              end
            end
          end
        end

        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_dense_streamer.sv
// -----------------------------------------------------------------------------
// tb_csr_dense_streamer
//
// Directed bench for csr_dense_streamer. Inputs are driven 1 time unit after
// each rising edge and outputs are observed at the same point. The cycle in
// which start_i is driven is cycle 0; the window after the next edge is
// cycle 1, and so on.
// -----------------------------------------------------------------------------
module tb_csr_dense_streamer;

  localparam int DW  = 32;
  localparam int NNZ = 16;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] rows;
  logic [IW:0]   cols;
  logic [DW-1:0] nv [NNZ];
  logic [IW-1:0] ci [NNZ];
  logic [IW-1:0] rp [NNZ];
  logic [DW-1:0] data;
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic          valid;
  logic          ready;
  logic          last_row_elem;
  logic          last;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Beats captured by run_stream.
  int            nbeats;
  logic [DW-1:0] b_data [64];
  logic [IW-1:0] b_row  [64];
  logic [IW-1:0] b_col  [64];
  logic          b_lre  [64];
  logic          b_last [64];
  int            done_cyc;
  int            done_count;
  int            first_valid_cyc;
  int            stall_bad;
  int            stall_seen;
  logic          busy_c1;

  csr_dense_streamer #(.DATA_W(DW), .MAX_NNZ(NNZ), .IDX_W(IW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .rows_i          (rows),
    .cols_i          (cols),
    .NV_i            (nv),
    .CI_i            (ci),
    .RP_i            (rp),
    .data_o          (data),
    .row_o           (row),
    .col_o           (col),
    .valid_o         (valid),
    .ready_i         (ready),
    .last_row_elem_o (last_row_elem),
    .last_o          (last),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_matrix();
    for (int i = 0; i < NNZ; i++) begin
      nv[i] = '0;
      ci[i] = '0;
      rp[i] = '0;
    end
  endtask

  task automatic load_2x3();
    clear_matrix();
    rows  = 4'd2;
    cols  = 5'd3;
    rp[0] = 4'd0; rp[1] = 4'd2; rp[2] = 4'd3;
    ci[0] = 4'd0; ci[1] = 4'd2; ci[2] = 4'd1;
    nv[0] = 32'd5; nv[1] = 32'd7; nv[2] = 32'd9;
  endtask

  // Pulses start in cycle 0, then observes cycles 1..budget. Optionally toggles
  // ready and re-pulses start at cycle inject_at (0 = never).
  task automatic run_stream(input bit toggle, input int budget, input int inject_at);
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_row;
    logic [IW-1:0] prev_col;
    nbeats          = 0;
    done_cyc        = -1;
    done_count      = 0;
    first_valid_cyc = -1;
    stall_bad       = 0;
    stall_seen      = 0;
    prev_stall      = 1'b0;
    prev_data       = '0;
    prev_row        = '0;
    prev_col        = '0;
    start = 1'b1;
    ready = 1'b1;
    step();
    busy_c1 = busy;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      start = (cyc == inject_at);
      ready = toggle ? cyc[0] : 1'b1;
      if (prev_stall) begin
        stall_seen++;
        if (valid !== 1'b1 || data !== prev_data || row !== prev_row || col !== prev_col)
          stall_bad++;
      end
      if (valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid === 1'b1 && ready === 1'b1 && nbeats < 64) begin
        b_data[nbeats] = data;
        b_row[nbeats]  = row;
        b_col[nbeats]  = col;
        b_lre[nbeats]  = last_row_elem;
        b_last[nbeats] = last;
        nbeats++;
      end
      if (done === 1'b1) begin
        done_count++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_stall = (valid === 1'b1) && (ready === 1'b0);
      prev_data  = data;
      prev_row   = row;
      prev_col   = col;
      step();
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b1; rows = '0; cols = '0;
    clear_matrix();
    step(); step();
    checks++;
    if ({valid, busy, done, err, last, last_row_elem} !== 6'b0 || data !== '0 || row !== '0 || col !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b busy=%0b done=%0b err=%0b data=%0d row=%0d col=%0d required all 0",
               valid, busy, done, err, data, row, col);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [DW-1:0] e_data [6] = '{32'd5, 32'd0, 32'd7, 32'd0, 32'd9, 32'd0};
    logic [IW-1:0] e_row  [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    logic [IW-1:0] e_col  [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    logic          e_lre  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic          e_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load_2x3();
    run_stream(1'b0, 14, 0);
    checks++;
    if (nbeats != 6) begin errors++; $display("FAIL basic_beats: got %0d required 6", nbeats); end
    for (int i = 0; i < 6 && i < nbeats; i++) begin
      checks++;
      if (b_data[i] !== e_data[i] || b_row[i] !== e_row[i] || b_col[i] !== e_col[i] ||
          b_lre[i] !== e_lre[i] || b_last[i] !== e_last[i]) begin
        errors++;
        $display("FAIL basic_beat%0d: got d=%0d r=%0d c=%0d lre=%0b last=%0b required d=%0d r=%0d c=%0d lre=%0b last=%0b",
                 i, b_data[i], b_row[i], b_col[i], b_lre[i], b_last[i],
                 e_data[i], e_row[i], e_col[i], e_lre[i], e_last[i]);
      end
    end
    checks++;
    if (first_valid_cyc != 2) begin errors++; $display("FAIL basic_first_valid: got cycle %0d required 2", first_valid_cyc); end
    checks++;
    if (done_cyc != 10 || done_count != 1) begin
      errors++; $display("FAIL basic_done: got cycle %0d count %0d required cycle 10 count 1", done_cyc, done_count);
    end
    checks++;
    if (busy_c1 !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %0b required 1", busy_c1); end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_end_flags: got err=%0b busy=%0b required err=0 busy=0", err, busy);
    end
  endtask

  task automatic test_ready_toggle();
    logic [DW-1:0] e_data [6] = '{32'd5, 32'd0, 32'd7, 32'd0, 32'd9, 32'd0};
    load_2x3();
    run_stream(1'b1, 30, 0);
    checks++;
    if (nbeats != 6) begin errors++; $display("FAIL toggle_beats: got %0d required 6", nbeats); end
    for (int i = 0; i < 6 && i < nbeats; i++) begin
      checks++;
      if (b_data[i] !== e_data[i] || b_col[i] !== 4'(i % 3) || b_row[i] !== 4'(i / 3)) begin
        errors++;
        $display("FAIL toggle_beat%0d: got d=%0d r=%0d c=%0d required d=%0d r=%0d c=%0d",
                 i, b_data[i], b_row[i], b_col[i], e_data[i], i / 3, i % 3);
      end
    end
    checks++;
    if (stall_seen == 0 || stall_bad != 0) begin
      errors++; $display("FAIL toggle_stall_stable: got %0d unstable of %0d stalls required 0 unstable", stall_bad, stall_seen);
    end
    checks++;
    if (done_count != 1 || err !== 1'b0) begin
      errors++; $display("FAIL toggle_done: got count %0d err %0b required count 1 err 0", done_count, err);
    end
  endtask

  task automatic test_zero_rows();
    clear_matrix();
    rows = 4'd0;
    cols = 5'd3;
    run_stream(1'b0, 6, 0);
    checks++;
    if (nbeats != 0 || first_valid_cyc != -1) begin
      errors++; $display("FAIL zero_rows_beats: got %0d beats required 0", nbeats);
    end
    checks++;
    if (done_cyc != 2 || done_count != 1) begin
      errors++; $display("FAIL zero_rows_done: got cycle %0d count %0d required cycle 2 count 1", done_cyc, done_count);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_rows_busy: got %0b required 0", busy); end
  endtask

  task automatic test_bad_order();
    logic [DW-1:0] e_data [3] = '{32'd0, 32'd0, 32'd11};
    clear_matrix();
    rows  = 4'd1;
    cols  = 5'd3;
    rp[0] = 4'd0; rp[1] = 4'd2;
    ci[0] = 4'd2; ci[1] = 4'd1;
    nv[0] = 32'd11; nv[1] = 32'd22;
    run_stream(1'b0, 10, 0);
    checks++;
    if (nbeats != 3) begin errors++; $display("FAIL bad_order_beats: got %0d required 3", nbeats); end
    for (int i = 0; i < 3 && i < nbeats; i++) begin
      checks++;
      if (b_data[i] !== e_data[i]) begin
        errors++; $display("FAIL bad_order_beat%0d: got %0d required %0d", i, b_data[i], e_data[i]);
      end
    end
    checks++;
    if (err !== 1'b1 || done_count != 1) begin
      errors++; $display("FAIL bad_order_err: got err=%0b done count %0d required err=1 count 1", err, done_count);
    end
  endtask

  task automatic test_identity();
    clear_matrix();
    rows = 4'd4;
    cols = 5'd4;
    for (int i = 0; i < 4; i++) begin
      rp[i] = 4'(i);
      ci[i] = 4'(i);
      nv[i] = 32'd1;
    end
    rp[4] = 4'd4;
    for (int pass = 0; pass < 2; pass++) begin
      // First pass pulses start mid-stream; it must be ignored.
      run_stream(1'b0, 26, (pass == 0) ? 8 : 0);
      checks++;
      if (nbeats != 16) begin errors++; $display("FAIL identity%0d_beats: got %0d required 16", pass, nbeats); end
      for (int i = 0; i < 16 && i < nbeats; i++) begin
        checks++;
        if (b_data[i] !== ((i / 4 == i % 4) ? 32'd1 : 32'd0) || b_last[i] !== (i == 15)) begin
          errors++;
          $display("FAIL identity%0d_beat%0d: got d=%0d last=%0b required d=%0d last=%0b",
                   pass, i, b_data[i], b_last[i], (i / 4 == i % 4) ? 1 : 0, (i == 15) ? 1 : 0);
        end
      end
      checks++;
      if (done_cyc != 22 || done_count != 1 || err !== 1'b0) begin
        errors++;
        $display("FAIL identity%0d_done: got cycle %0d count %0d err %0b required cycle 22 count 1 err 0",
                 pass, done_cyc, done_count, err);
      end
    end
  endtask

  task automatic test_cols_zero();
    clear_matrix();
    rows  = 4'd1;
    cols  = 5'd0;
    rp[0] = 4'd0; rp[1] = 4'd1;
    ci[0] = 4'd15;
    nv[0] = 32'd42;
    run_stream(1'b0, 22, 0);
    checks++;
    if (nbeats != 16) begin errors++; $display("FAIL cols_zero_beats: got %0d required 16", nbeats); end
    if (nbeats == 16) begin
      checks++;
      if (b_data[15] !== 32'd42 || b_col[15] !== 4'd15 || b_last[15] !== 1'b1 ||
          b_data[14] !== 32'd0 || b_lre[14] !== 1'b0) begin
        errors++;
        $display("FAIL cols_zero_tail: got d15=%0d c15=%0d last15=%0b d14=%0d lre14=%0b required 42 15 1 0 0",
                 b_data[15], b_col[15], b_last[15], b_data[14], b_lre[14]);
      end
    end
    checks++;
    if (done_cyc != 19 || err !== 1'b0) begin
      errors++; $display("FAIL cols_zero_done: got cycle %0d err %0b required cycle 19 err 0", done_cyc, err);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    load_2x3();
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 6; cyc++) step();
    checks++;
    if (valid !== 1'b1 || row !== 4'd1) begin
      errors++; $display("FAIL reset_mid_row1: got valid=%0b row=%0d required valid=1 row=1", valid, row);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got valid=%0b busy=%0b err=%0b done=%0b required all 0", valid, busy, err, done);
    end
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || valid === 1'b1) done_seen++;
      step();
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d active cycles required 0", done_seen); end
    run_stream(1'b0, 14, 0);
    checks++;
    if (nbeats != 6 || done_cyc != 10 || b_data[0] !== 32'd5 || b_data[4] !== 32'd9) begin
      errors++;
      $display("FAIL reset_mid_rerun: got beats %0d done cycle %0d d0=%0d d4=%0d required 6 10 5 9",
               nbeats, done_cyc, b_data[0], b_data[4]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_zero_rows();
    test_bad_order();
    test_identity();
    test_cols_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
